// File: rtl/decode_pkg.sv
// Shared decode definitions for the RV32I decode stage: opcodes, ALU and
// result-select encodings, immediate formats and the bubble control word.
package decode_pkg;

    localparam logic [6:0] OpLoad   = 7'b0000011;
    localparam logic [6:0] OpStore  = 7'b0100011;
    localparam logic [6:0] OpRType  = 7'b0110011;
    localparam logic [6:0] OpIAlu   = 7'b0010011;
    localparam logic [6:0] OpBranch = 7'b1100011;
    localparam logic [6:0] OpJal    = 7'b1101111;

    typedef enum logic [2:0] {
        AluAdd = 3'b000,
        AluSub = 3'b001,
        AluAnd = 3'b010,
        AluOr  = 3'b011,
        AluSlt = 3'b101
    } alu_ctrl_e;

    typedef enum logic [1:0] {
        ResAlu = 2'b00,
        ResMem = 2'b01,
        ResPc4 = 2'b10
    } result_src_e;

    typedef enum logic [2:0] {
        ImmNone,
        ImmI,
        ImmS,
        ImmB,
        ImmJ
    } imm_type_e;

    typedef struct packed {
        logic        reg_write;
        logic        mem_write;
        logic        jump;
        logic        branch;
        logic        alu_src;
        result_src_e result_src;
        alu_ctrl_e   alu_ctrl;
    } ctrl_t;

    localparam ctrl_t CtrlBubble = '{
        reg_write:  1'b0,
        mem_write:  1'b0,
        jump:       1'b0,
        branch:     1'b0,
        alu_src:    1'b0,
        result_src: ResAlu,
        alu_ctrl:   AluAdd
    };

    // Sign-extended immediate for the given instruction format.
    function automatic logic [31:0] imm_ext(logic [31:0] instr, imm_type_e imm_type);
        logic [31:0] imm;
        case (imm_type)
            ImmI:    imm = {{20{instr[31]}}, instr[31:20]};
            ImmS:    imm = {{20{instr[31]}}, instr[31:25], instr[11:7]};
            ImmB:    imm = {{20{instr[31]}}, instr[7], instr[30:25], instr[11:8], 1'b0};
            ImmJ:    imm = {{12{instr[31]}}, instr[19:12], instr[20], instr[30:21], 1'b0};
            default: imm = '0;
        endcase
        return imm;
    endfunction

    // ALU function from funct3; use_sub only matters for funct3=000.
    function automatic alu_ctrl_e alu_sel(logic [2:0] funct3, logic use_sub);
        alu_ctrl_e sel;
        case (funct3)
            3'b000:  sel = use_sub ? AluSub : AluAdd;
            3'b010:  sel = AluSlt;
            3'b110:  sel = AluOr;
            3'b111:  sel = AluAnd;
            default: sel = AluAdd;
        endcase
        return sel;
    endfunction

endpackage

// File: rtl/register_file.sv
// 2-read / 1-write architectural register file with x0 hardwired to zero.
// Build option REGFILE_BYPASS_EN: a same-cycle write to the register being
// read is forwarded to the read port (write-through).
module register_file
    import decode_pkg::*;
#(
    parameter int unsigned XLEN  = 32,
    parameter int unsigned NREGS = 32,
    localparam int unsigned AW   = $clog2(NREGS)
) (
    input  logic            clk_i,
    input  logic            rst_ni,
    input  logic            we_i,
    input  logic [AW-1:0]   waddr_i,
    input  logic [XLEN-1:0] wdata_i,
    input  logic [AW-1:0]   raddr1_i,
    input  logic [AW-1:0]   raddr2_i,
    output logic [XLEN-1:0] rdata1_o,
    output logic [XLEN-1:0] rdata2_o
);

    logic [XLEN-1:0] mem_q [NREGS];

    // Storage: cleared on reset, x0 never written.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < NREGS; i++) begin
                mem_q[i] <= '0;
            end
        end else if (we_i && (waddr_i != '0)) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    // Combinational read ports; x0 always reads as zero.
    always_comb begin
        rdata1_o = (raddr1_i == '0) ? '0 : mem_q[raddr1_i];
        rdata2_o = (raddr2_i == '0) ? '0 : mem_q[raddr2_i];
`ifdef REGFILE_BYPASS_EN
        if (we_i && (waddr_i != '0) && (waddr_i == raddr1_i)) begin
            rdata1_o = wdata_i;
        end
        if (we_i && (waddr_i != '0) && (waddr_i == raddr2_i)) begin
            rdata2_o = wdata_i;
        end
`endif
    end

endmodule

// File: rtl/decode_stage.sv
// RV32I instruction decode stage: decode, register-file read, load-use stall,
// taken-branch squash and the ID/EX pipeline register.
// Build option REGFILE_BYPASS_EN enables write-through in the register file.
module decode_stage
    import decode_pkg::*;
#(
    parameter int unsigned XLEN  = 32,
    parameter int unsigned NREGS = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [XLEN-1:0] InstrD,
    input  logic [XLEN-1:0] PCD,
    input  logic [XLEN-1:0] PCPlus4D,
    input  logic            PCSrcE,
    input  logic            RegWriteW,
    input  logic [4:0]      RdW,
    input  logic [XLEN-1:0] ResultW,
    output logic            PCWrite,
    output logic            IF_ID_Write,
    output logic            RegWriteE,
    output logic            MemWriteE,
    output logic            JumpE,
    output logic            BranchE,
    output logic            ALUSrcE,
    output logic [1:0]      ResultSrcE,
    output logic [2:0]      ALUControlE,
    output logic [XLEN-1:0] RD1E,
    output logic [XLEN-1:0] RD2E,
    output logic [XLEN-1:0] ImmExtE,
    output logic [XLEN-1:0] PCE,
    output logic [XLEN-1:0] PCPlus4E,
    output logic [4:0]      Rs1E,
    output logic [4:0]      Rs2E,
    output logic [4:0]      RdE
);

    typedef struct packed {
        ctrl_t           ctrl;
        logic [XLEN-1:0] rd1;
        logic [XLEN-1:0] rd2;
        logic [XLEN-1:0] imm;
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] pc4;
        logic [4:0]      rs1;
        logic [4:0]      rs2;
        logic [4:0]      rd;
    } idex_t;

    idex_t     idex_q, idex_d;
    logic      squash_q, squash_d;
    ctrl_t     ctrl;
    imm_type_e imm_type;
    logic      instr_valid;
    logic      stall_raw, stall, flush;
    logic [XLEN-1:0] rdata1, rdata2;

    logic [6:0] opcode;
    logic [2:0] funct3;
    logic [4:0] rs1_d, rs2_d, rd_d;

    assign opcode = InstrD[6:0];
    assign funct3 = InstrD[14:12];
    assign rs1_d  = InstrD[19:15];
    assign rs2_d  = InstrD[24:20];
    assign rd_d   = InstrD[11:7];

    register_file #(
        .XLEN  (XLEN),
        .NREGS (NREGS)
    ) u_register_file (
        .clk_i    (clk),
        .rst_ni   (rst),
        .we_i     (RegWriteW),
        .waddr_i  (RdW),
        .wdata_i  (ResultW),
        .raddr1_i (rs1_d),
        .raddr2_i (rs2_d),
        .rdata1_o (rdata1),
        .rdata2_o (rdata2)
    );

    // Main decoder: control word and immediate format per opcode.
    always_comb begin
        ctrl        = CtrlBubble;
        imm_type    = ImmNone;
        instr_valid = 1'b1;
        case (opcode)
            OpLoad: begin
                ctrl.reg_write  = 1'b1;
                ctrl.alu_src    = 1'b1;
                ctrl.result_src = ResMem;
                imm_type        = ImmI;
            end
            OpStore: begin
                ctrl.mem_write = 1'b1;
                ctrl.alu_src   = 1'b1;
                imm_type       = ImmS;
            end
            OpRType: begin
                ctrl.reg_write = 1'b1;
                ctrl.alu_ctrl  = alu_sel(funct3, InstrD[30]);
            end
            OpIAlu: begin
                // Bit 30 is immediate data here, so never a subtract.
                ctrl.reg_write = 1'b1;
                ctrl.alu_src   = 1'b1;
                ctrl.alu_ctrl  = alu_sel(funct3, 1'b0);
                imm_type       = ImmI;
            end
            OpBranch: begin
                ctrl.branch   = 1'b1;
                ctrl.alu_ctrl = AluSub;
                imm_type      = ImmB;
            end
            OpJal: begin
                ctrl.jump       = 1'b1;
                ctrl.reg_write  = 1'b1;
                ctrl.result_src = ResPc4;
                imm_type        = ImmJ;
            end
            default: instr_valid = 1'b0;
        endcase
    end

    // Hazard control: load-use stall, overridden by a taken branch or squash.
    always_comb begin
        // rs fields are compared even when the instruction does not use them.
        stall_raw   = (idex_q.ctrl.result_src == ResMem) && idex_q.ctrl.reg_write &&
                      (idex_q.rd != 5'd0) && ((idex_q.rd == rs1_d) || (idex_q.rd == rs2_d));
        stall       = stall_raw && !squash_q && !PCSrcE;
        flush       = PCSrcE || squash_q || stall || !instr_valid;
        PCWrite     = !stall;
        IF_ID_Write = !stall;
        squash_d    = PCSrcE;
    end

    // ID/EX next state: decoded instruction or an all-zero bubble.
    always_comb begin
        idex_d.ctrl = ctrl;
        idex_d.rd1  = rdata1;
        idex_d.rd2  = rdata2;
        idex_d.imm  = imm_ext(InstrD, imm_type);
        idex_d.pc   = PCD;
        idex_d.pc4  = PCPlus4D;
        idex_d.rs1  = rs1_d;
        idex_d.rs2  = rs2_d;
        idex_d.rd   = rd_d;
        if (flush) begin
            idex_d      = '0;
            idex_d.ctrl = CtrlBubble;
        end
    end

    // ID/EX register and squash flag; reset drops any pending squash.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            idex_q   <= '0;
            squash_q <= 1'b0;
        end else begin
            idex_q   <= idex_d;
            squash_q <= squash_d;
        end
    end

    assign RegWriteE   = idex_q.ctrl.reg_write;
    assign MemWriteE   = idex_q.ctrl.mem_write;
    assign JumpE       = idex_q.ctrl.jump;
    assign BranchE     = idex_q.ctrl.branch;
    assign ALUSrcE     = idex_q.ctrl.alu_src;
    assign ResultSrcE  = idex_q.ctrl.result_src;
    assign ALUControlE = idex_q.ctrl.alu_ctrl;
    assign RD1E        = idex_q.rd1;
    assign RD2E        = idex_q.rd2;
    assign ImmExtE     = idex_q.imm;
    assign PCE         = idex_q.pc;
    assign PCPlus4E    = idex_q.pc4;
    assign Rs1E        = idex_q.rs1;
    assign Rs2E        = idex_q.rs2;
    assign RdE         = idex_q.rd;

endmodule

// File: doc/decode_stage.md
# decode_stage

Instruction decode stage of the five-stage RV32I pipeline. It is the consuming end of the IF/ID interface: it takes InstrD, PCD and PCPlus4D, decodes them, and reads the register file. It generates the PCWrite and IF_ID_Write stall controls back to fetch, and squashes wrong-path instructions after a taken branch. It owns the 32x32 register file and the ID/EX pipeline register.

## Interface
Parameters:
- XLEN, 32, datapath width.
- NREGS, 32, architectural register count; x0 is hardwired to zero.

Ports:
- clk  in  1  single pipeline clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- InstrD, PCD, PCPlus4D  in  32 each  IF/ID register contents.
- PCSrcE  in  1  branch/jump taken in EX this cycle.
- RegWriteW  in  1  writeback enable.
- RdW  in  5  writeback destination.
- ResultW  in  32  writeback data.
- PCWrite  out  1  to fetch; 0 stalls the PC.
- IF_ID_Write  out  1  to fetch; 0 holds IF/ID.
- RegWriteE, MemWriteE, JumpE, BranchE, ALUSrcE  out  1 each  registered controls.
- ResultSrcE  out  2  00 ALU, 01 memory, 10 PC+4.
- ALUControlE  out  3  000 add, 001 sub, 010 and, 011 or, 101 slt.
- RD1E, RD2E, ImmExtE, PCE, PCPlus4E  out  32 each  registered operands.
- Rs1E, Rs2E, RdE  out  5 each  registered register indices.

## Operation
- Decoded opcodes: lw 0000011, sw 0100011, R-type 0110011, I-ALU 0010011, beq 1100011, jal 1101111. Any other opcode, including 0x00000000, decodes as a bubble.
- Bubble: RegWriteE, MemWriteE, BranchE and JumpE are 0. All other ID/EX fields are 0.
- Immediates are sign-extended from bit 31:
  - I-type: [31:20].
  - S-type: {[31:25],[11:7]}.
  - B-type: {[31],[7],[30:25],[11:8],0}.
  - J-type: {[31],[19:12],[20],[30:21],0}.
- ALU function selection:
  - R-type: funct3/funct7[5] select the function; sub only when funct7[5]=1.
  - I-ALU: never uses sub.
  - lw, sw, jal: add.
  - beq: sub.
- Register file:
  - Two combinational read ports (Rs1D=InstrD[19:15], Rs2D=InstrD[24:20]) and one write port written on the rising edge when RegWriteW=1 and RdW!=0.
  - Writes to x0 are ignored; reads of x0 return 0.
- Load-use hazard detection:
  - StallD = ResultSrcE==01 && RegWriteE && RdE!=0 && (RdE==Rs1D || RdE==Rs2D).
  - The comparison uses the decoded rs fields regardless of whether the instruction actually uses them.
- squash flag:
  - Set on the clock edge where PCSrcE=1; cleared on the next edge unless PCSrcE=1 again.
  - While squash=1, the instruction in D is a wrong-path fetch: ID/EX loads a bubble and StallD is forced to 0.
- Priority, highest first:
  1. PCSrcE=1: ID/EX loads a bubble; PCWrite=1, IF_ID_Write=1.
  2. squash=1: ID/EX loads a bubble.
  3. StallD=1: ID/EX loads a bubble; PCWrite=0, IF_ID_Write=0.
  4. Otherwise ID/EX loads the decoded instruction.

## Timing
- Reset (rst=0): all ID/EX outputs 0, squash=0, all 32 registers 0; PCWrite=1, IF_ID_Write=1. Reset mid-operation discards any pending squash and stall.
- PCWrite and IF_ID_Write are combinational from ID/EX and InstrD, with no added latency.
- The ID/EX register has a latency of 1 cycle; it updates on every rising edge and has no hold.
- A load-use stall lasts exactly 1 cycle: the bubble clears the ID/EX load condition.
- A taken branch inserts exactly 2 bubbles: the D instruction in the PCSrcE cycle, and the following cycle's D via squash.
- PCSrcE in two consecutive cycles keeps squash set; the rules above still apply each cycle.

## Configuration
- REGFILE_BYPASS_EN defined: a write and a read of the same nonzero register in the same cycle return ResultW (write-through).
- REGFILE_BYPASS_EN undefined: such a read returns the old stored value.
  - WB to D forwarding must then be handled elsewhere.

## Structure
- decode_pkg holds:
  - Opcode constants.
  - ALUControl encodings.
  - ResultSrc encodings.
  - Immediate-type enum.
  - The bubble control constant.
- One sub-module, register_file, contains the array, the x0 rule and the REGFILE_BYPASS_EN logic.
- Decode, hazard/squash logic and the ID/EX register stay in decode_stage.

## Test plan
- Reset with InstrD=0x00500093 (addi x1,x0,5), then release → first edge: RegWriteE=1, ALUSrcE=1, ImmExtE=5, RdE=1, ALUControlE=000.
- Writeback RdW=3, ResultW=0xDEADBEEF, RegWriteW=1 while InstrD=0x00018133 (add x2,x3,x0) → RD1E=0xDEADBEEF with REGFILE_BYPASS_EN, 0 without.
- lw x5,0(x1) in E, add x6,x5,x7 in D → PCWrite=0, IF_ID_Write=0 for one cycle, ID/EX bubble, then the add issues with Rs1E=5.
- PCSrcE=1 for one cycle with a valid instruction in D → two consecutive bubbles in ID/EX (RegWriteE=MemWriteE=0), PCWrite stays 1.
- PCSrcE=1 coinciding with a load-use match → no stall (PCWrite=1), bubble loaded.
- Write RdW=0, ResultW=0x1234 → a subsequent read of x0 gives RD1E=0. sw x2,-4(x1) (0xFE20AE23) → MemWriteE=1, ImmExtE=0xFFFFFFFC.
